// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit owning the HI/LO registers
// Multiply commits after MUL_LAT cycles; divide retires DIV_BPC quotient bits per cycle, then fixes signs.
module muldiv_unit #(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 1,
    parameter int DIV_BPC = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        mul_control,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] wdata,
    input  logic              flush,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              done
);
    localparam int DIV_ITERS = DATA_W / DIV_BPC;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t              state_q, state_d;
    logic [31:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [DATA_W-1:0]   quo_q, quo_d;
    logic [DATA_W:0]     rem_q, rem_d;
    logic                sgn_q, sgn_d;
    logic                done_q, done_d;

    logic                op_onehot, src_signed, a_neg, b_neg;
    logic [DATA_W-1:0]   src_a_mag, b_mag;
    logic [2*DATA_W-1:0] ext_a, ext_b, prod;
    logic [DATA_W:0]     r_step;
    logic [DATA_W-1:0]   q_step;

    assign op_onehot  = $onehot(mul_control);
    assign src_signed = mul_control[0] | mul_control[2];
    assign src_a_mag  = (src_signed && src_a[DATA_W-1]) ? -src_a : src_a;

    assign a_neg = sgn_q & a_q[DATA_W-1];
    assign b_neg = sgn_q & b_q[DATA_W-1];
    assign b_mag = b_neg ? -b_q : b_q;

    // Sign-extending to full product width makes one multiplier serve both signednesses.
    assign ext_a = sgn_q ? {{DATA_W{a_q[DATA_W-1]}}, a_q} : {{DATA_W{1'b0}}, a_q};
    assign ext_b = sgn_q ? {{DATA_W{b_q[DATA_W-1]}}, b_q} : {{DATA_W{1'b0}}, b_q};
    assign prod  = ext_a * ext_b;

    always_comb begin
        r_step = rem_q;
        q_step = quo_q;
        for (int i = 0; i < DIV_BPC; i++) begin
            r_step = {r_step[DATA_W-1:0], q_step[DATA_W-1]};
            q_step = {q_step[DATA_W-2:0], 1'b0};
            if (r_step >= {1'b0, b_mag}) begin
                r_step    = r_step - {1'b0, b_mag};
                q_step[0] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        sgn_d   = sgn_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid && !flush) begin
                    if (op_onehot) begin
                        a_d   = src_a;
                        b_d   = src_b;
                        sgn_d = src_signed;
                        quo_d = src_a_mag;
                        rem_d = '0;
                        if (mul_control[2] || mul_control[3]) begin
                            state_d = S_DIV;
                            cnt_d   = 32'(DIV_ITERS - 1);
                        end else begin
                            state_d = S_MUL;
                            cnt_d   = 32'(MUL_LAT - 1);
                        end
                    end else begin
                        if (hi_we) hi_d = wdata;
                        if (lo_we) lo_d = wdata;
                    end
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    hi_d    = prod[2*DATA_W-1:DATA_W];
                    lo_d    = prod[DATA_W-1:0];
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = r_step;
                    quo_d = q_step;
                    if (cnt_q == '0) state_d = S_FIX;
                    else             cnt_d   = cnt_q - 32'd1;
                end
            end
            default: begin
                if (!flush) begin
                    // MIN/-1 falls out naturally: |MIN| wraps to MIN and negating it yields MIN.
                    if (b_q == '0) begin
                        lo_d = '1;
                        hi_d = a_q;
                    end else begin
                        lo_d = (a_neg ^ b_neg) ? -quo_q : quo_q;
                        hi_d = a_neg ? -rem_q[DATA_W-1:0] : rem_q[DATA_W-1:0];
                    end
                    done_d = 1'b1;
                end
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            sgn_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            sgn_q   <= sgn_d;
            done_q  <= done_d;
        end
    end

    assign hi        = hi_q;
    assign lo        = lo_q;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE);
    assign req_ready = (state_q == S_IDLE);
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
    localparam int MUL16 = 3;

    logic        clk = 1'b0;
    logic        resetn;
    logic        rv32, rv16, flush, hi_we, lo_we;
    logic [3:0]  ctl;
    logic [31:0] a, b, wdata;
    logic        rr32, busy32, done32, rr16, busy16, done16;
    logic [31:0] hi32, lo32;
    logic [15:0] hi16, lo16;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.DATA_W(32), .MUL_LAT(1), .DIV_BPC(1)) u_dut32 (
        .clk(clk), .resetn(resetn), .req_valid(rv32), .req_ready(rr32),
        .mul_control(ctl), .src_a(a), .src_b(b), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata), .flush(flush), .hi(hi32), .lo(lo32), .busy(busy32), .done(done32)
    );

    muldiv_unit #(.DATA_W(16), .MUL_LAT(MUL16), .DIV_BPC(2)) u_dut16 (
        .clk(clk), .resetn(resetn), .req_valid(rv16), .req_ready(rr16),
        .mul_control(ctl), .src_a(a[15:0]), .src_b(b[15:0]), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata[15:0]), .flush(flush), .hi(hi16), .lo(lo16), .busy(busy16), .done(done16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] hi_of(input int u);
        return (u != 0) ? {16'h0, hi16} : hi32;
    endfunction
    function automatic logic [31:0] lo_of(input int u);
        return (u != 0) ? {16'h0, lo16} : lo32;
    endfunction
    function automatic logic busy_of(input int u);
        return (u != 0) ? busy16 : busy32;
    endfunction
    function automatic logic done_of(input int u);
        return (u != 0) ? done16 : done32;
    endfunction

    // Reference: plain signed/unsigned integer arithmetic on the operand values.
    function automatic void ref_model(input int w, input logic [3:0] c,
                                      input longint unsigned xa, input longint unsigned xb,
                                      output longint unsigned eh, output longint unsigned el);
        longint unsigned mask = (64'd1 << w) - 64'd1;
        longint unsigned mn   = 64'd1 << (w - 1);
        longint          sa   = ((xa & mn) != 0) ? longint'(xa) - longint'(64'd1 << w) : longint'(xa);
        longint          sb   = ((xb & mn) != 0) ? longint'(xb) - longint'(64'd1 << w) : longint'(xb);
        longint unsigned p;
        eh = 0;
        el = 0;
        if (c[0] || c[1]) begin
            p  = c[0] ? longint'(sa * sb) : xa * xb;
            eh = (p >> w) & mask;
            el = p & mask;
        end else if (xb == 0) begin
            el = mask;
            eh = xa;
        end else if (c[2]) begin
            if (sa == -longint'(mn) && sb == -1) begin
                el = mn;
                eh = 0;
            end else begin
                el = longint'(sa / sb) & mask;
                eh = longint'(sa % sb) & mask;
            end
        end else begin
            el = xa / xb;
            eh = xa % xb;
        end
    endfunction

    task automatic do_op(input int u, input logic [3:0] c, input logic [31:0] xa_in,
                         input logic [31:0] xb_in, input string tag);
        int              w   = (u != 0) ? 16 : 32;
        int              lat = (c[0] || c[1]) ? ((u != 0) ? MUL16 : 1) : ((u != 0) ? 9 : 33);
        logic [31:0]     xa  = (u != 0) ? (xa_in & 32'hFFFF) : xa_in;
        logic [31:0]     xb  = (u != 0) ? (xb_in & 32'hFFFF) : xb_in;
        longint unsigned eh, el;
        int              cyc = 0;
        bit              seen = 0;
        ref_model(w, c, 64'(xa), 64'(xb), eh, el);
        ctl = c;
        a   = xa;
        b   = xb;
        if (u != 0) rv16 = 1'b1;
        else        rv32 = 1'b1;
        @(posedge clk);
        #1;
        rv32 = 1'b0;
        rv16 = 1'b0;
        ctl  = 4'b0;
        check({tag, " busy_after_accept"}, 64'(busy_of(u)), 64'd1);
        while (!seen && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done_of(u)) seen = 1;
        end
        check({tag, " latency"}, 64'(cyc), 64'(lat));
        check({tag, " busy_at_done"}, 64'(busy_of(u)), 64'd0);
        check({tag, " hi"}, 64'(hi_of(u)), eh);
        check({tag, " lo"}, 64'(lo_of(u)), el);
    endtask

    function automatic logic [31:0] pick(input int w);
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'h0;
            1:       v = 32'h1 << (w - 1);
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'h1;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int  cyc;
        bit  saw_done;
        resetn = 1'b0;
        rv32 = 0; rv16 = 0; flush = 0; hi_we = 0; lo_we = 0;
        ctl = 0; a = 0; b = 0; wdata = 0;
        #12;
        check("reset hi", 64'(hi32), 64'd0);
        check("reset lo", 64'(lo32), 64'd0);
        check("reset busy", 64'(busy32), 64'd0);
        check("reset done", 64'(done32), 64'd0);
        check("reset ready", 64'(rr32), 64'd1);
        check("reset ready16", 64'(rr16), 64'd1);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        do_op(0, 4'b0001, 32'hFFFF_FFFF, 32'h2, "mult_neg1x2");
        do_op(0, 4'b0010, 32'hFFFF_FFFF, 32'h2, "multu_maxx2");
        do_op(0, 4'b0100, 32'hFFFF_FFF9, 32'h2, "div_m7_2");
        do_op(0, 4'b1000, 32'd100, 32'd7, "divu_100_7");
        do_op(0, 4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        do_op(0, 4'b1000, 32'd5, 32'd0, "divu_by_zero");
        do_op(0, 4'b0100, 32'hFFFF_FFF9, 32'd0, "div_by_zero");

        // Flush mid-divide: no commit, HI/LO keep their MTHI/MTLO values.
        rv32 = 1; hi_we = 1; lo_we = 1; wdata = 32'h11;
        @(posedge clk);
        #1;
        rv32 = 0; hi_we = 0; lo_we = 0;
        ctl = 4'b1000; a = 32'd1000; b = 32'd3; rv32 = 1;
        @(posedge clk);
        #1;
        rv32 = 0; ctl = 0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        flush = 1;
        @(posedge clk);
        #1;
        flush = 0;
        check("flush busy", 64'(busy32), 64'd0);
        check("flush ready", 64'(rr32), 64'd1);
        check("flush hi", 64'(hi32), 64'h11);
        check("flush lo", 64'(lo32), 64'h11);
        saw_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done32) saw_done = 1;
        end
        check("flush no_done", 64'(saw_done), 64'd0);
        do_op(0, 4'b0001, 32'd3, 32'd4, "mult_after_flush");

        // MTHI offered during a divide waits for the unit to go idle.
        ctl = 4'b1000; a = 32'd100; b = 32'd7; rv32 = 1;
        @(posedge clk);
        #1;
        ctl = 0; hi_we = 1; wdata = 32'h1234;
        check("mthi_hold ready", 64'(rr32), 64'd0);
        cyc = 0;
        while (!rr32 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("mthi_hold wait", 64'(cyc), 64'd33);
        @(posedge clk);
        #1;
        rv32 = 0; hi_we = 0;
        check("mthi_hold hi", 64'(hi32), 64'h1234);
        check("mthi_hold lo", 64'(lo32), 64'hE);
        rv32 = 1; hi_we = 1; lo_we = 1; wdata = 32'hAB;
        @(posedge clk);
        #1;
        rv32 = 0; hi_we = 0; lo_we = 0;
        check("mthi_mtlo hi", 64'(hi32), 64'hAB);
        check("mthi_mtlo lo", 64'(lo32), 64'hAB);

        // Writes offered alongside an op are dropped; do_op checks HI/LO against the op result.
        hi_we = 1; lo_we = 1; wdata = 32'h55;
        do_op(0, 4'b0001, 32'hFFFF_FFFD, 32'd5, "op_with_we");
        hi_we = 0; lo_we = 0;

        ctl = 4'b0011; a = 32'd9; b = 32'd9; rv32 = 1;
        @(posedge clk);
        #1;
        rv32 = 0; ctl = 0;
        check("multihot busy", 64'(busy32), 64'd0);
        check("multihot lo", 64'(lo32), 64'hFFFF_FFF1);

        do_op(1, 4'b1000, 32'hFFFF, 32'h3, "divu16_ffff_3");
        do_op(1, 4'b0001, 32'hFFFF, 32'h8000, "mult16");

        for (int i = 0; i < 60; i++) begin
            int          u = $urandom_range(0, 1);
            logic [3:0]  c = 4'b0001 << $urandom_range(0, 3);
            logic [31:0] xa = pick((u != 0) ? 16 : 32);
            logic [31:0] xb = pick((u != 0) ? 16 : 32);
            do_op(u, c, xa, xb, $sformatf("rand%0d", i));
        end

        // Asynchronous reset mid-divide clears state without a clock edge.
        ctl = 4'b1000; a = 32'd77; b = 32'd5; rv32 = 1;
        @(posedge clk);
        #1;
        rv32 = 0; ctl = 0;
        repeat (5) @(posedge clk);
        #3;
        resetn = 0;
        #1;
        check("async_reset hi", 64'(hi32), 64'd0);
        check("async_reset lo", 64'(lo32), 64'd0);
        check("async_reset busy", 64'(busy32), 64'd0);
        check("async_reset ready", 64'(rr32), 64'd1);
        #2;
        resetn = 1;
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
